// File: rtl/cmos_to_sobel_pkg.sv
// Shared definitions for the camera-to-Sobel path: output modes, gray weights, thresholds.
// Pure definitions, no latency; no flow control.
// Used by the top and the window sub-module.
package cmos_to_sobel_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY  = 2'b00,
        MODE_SOBEL = 2'b01,
        MODE_RAW   = 2'b10,
        MODE_BIN   = 2'b11
    } mode_e;

    localparam int         GRAY_W_R   = 4;
    localparam int         GRAY_W_G   = 10;
    localparam int         GRAY_W_B   = 2;
    localparam int         GRAY_SHIFT = 4;
    localparam int         BIN_THRESH = 128;
    localparam logic [7:0] MAG_MAX    = 8'd255;

    // Per-pixel state carried alongside the Sobel pipeline so all modes share one latency.
    typedef struct packed {
        logic        vld;
        logic        sof;
        logic        eol;
        logic        last;
        logic        edge_ok;
        logic [15:0] rgb;
        logic [7:0]  gray;
    } pix_meta_t;

    // Weights sum to 16, so the 12-bit accumulator tops out at 4008 and never wraps.
    function automatic logic [7:0] rgb565_to_gray(input logic [15:0] rgb);
        logic [11:0] r8, g8, b8, acc;
        r8  = {4'b0, rgb[15:11], 3'b0};
        g8  = {4'b0, rgb[10:5], 2'b0};
        b8  = {4'b0, rgb[4:0], 3'b0};
        acc = 12'(GRAY_W_R) * r8 + 12'(GRAY_W_G) * g8 + 12'(GRAY_W_B) * b8;
        return 8'(acc >> GRAY_SHIFT);
    endfunction

endpackage

// File: rtl/cmos_to_sobel_sobel_window3x3.sv
// 3x3 gray window from two line buffers plus the live pixel; Sobel |gx|+|gy| clamped to 255.
// Window loads on the accept edge, mag is registered two edges later.
// No backpressure: one pixel may be pushed on any cycle in_vld is high.
module sobel_window3x3
    import cmos_to_sobel_pkg::*;
#(
    parameter int MAX_H = 1280,
    parameter int AW    = $clog2(MAX_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [AW-1:0] in_col,
    input  logic [7:0]    in_gray,
    output logic [7:0]    mag
);

    logic [7:0] lb0 [MAX_H];
    logic [7:0] lb1 [MAX_H];
    logic [7:0] win [3][3];
    logic [7:0] up1, up2;

    // lb0 holds row r-1 and lb1 row r-2 at this column until the write below.
    assign up1 = lb0[in_col];
    assign up2 = lb1[in_col];

    // Contents are don't-care after reset: the r<2 / c<2 mask hides stale data.
    always_ff @(posedge clk) begin
        if (in_vld) begin
            lb0[in_col] <= in_gray;
            lb1[in_col] <= up1;
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= up2;
            win[1][2] <= up1;
            win[2][2] <= in_gray;
        end
    end

    logic [10:0]        gx_p, gx_n, gy_p, gy_n;
    logic signed [10:0] gx, gy;
    logic [10:0]        gx_abs, gy_abs, ax, ay;
    logic [11:0]        sum;

    assign gx_p = {3'b0, win[0][2]} + {2'b0, win[1][2], 1'b0} + {3'b0, win[2][2]};
    assign gx_n = {3'b0, win[0][0]} + {2'b0, win[1][0], 1'b0} + {3'b0, win[2][0]};
    assign gy_p = {3'b0, win[2][0]} + {2'b0, win[2][1], 1'b0} + {3'b0, win[2][2]};
    assign gy_n = {3'b0, win[0][0]} + {2'b0, win[0][1], 1'b0} + {3'b0, win[0][2]};
    assign gx   = $signed(gx_p - gx_n);
    assign gy   = $signed(gy_p - gy_n);
    assign gx_abs = gx[10] ? 11'(-gx) : 11'(gx);
    assign gy_abs = gy[10] ? 11'(-gy) : 11'(gy);
    assign sum  = {1'b0, ax} + {1'b0, ay};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ax  <= '0;
            ay  <= '0;
            mag <= '0;
        end else begin
            ax  <= gx_abs;
            ay  <= gy_abs;
            mag <= (sum > 12'(MAG_MAX)) ? MAG_MAX : sum[7:0];
        end
    end

endmodule

// File: rtl/cmos_to_sobel.sv
// DVP byte pairing to RGB565, grayscale, Sobel, mode mux, per-frame latches and frame-done CDC.
// pix_valid follows the edge sampling a pixel's second byte by 3 clk cycles in every mode.
// No backpressure: the camera cannot stall, so every accepted pixel is emitted.
module cmos_to_sobel
    import cmos_to_sobel_pkg::*;
#(
    parameter int MAX_H = 1280
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eth_clk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic [15:0] cmos_h,
    input  logic [15:0] cmos_v,
    input  logic [1:0]  mode,
    input  logic [31:0] pc_ip,
    input  logic [47:0] pc_mac,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic [31:0] dst_ip,
    output logic [47:0] dst_mac,
    output logic        frame_done_eth
);

    localparam int AW = $clog2(MAX_H);

    logic        href_d, phase, line_acc, done_tgl;
    logic [7:0]  byte_hi;
    logic [15:0] row, col;
    mode_e       mode_q;
    logic [15:0] rgb;
    logic [7:0]  gray, mag, mag_m;
    logic        accept;
    pix_meta_t   s0, s1, s2, s3;
    logic [15:0] out_data;

    assign rgb    = {byte_hi, cam_data};
    assign gray   = rgb565_to_gray(rgb);
    assign accept = cam_href && phase && !cam_vsync && (col < cmos_h) && (row < cmos_v);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            href_d   <= 1'b0;
            phase    <= 1'b0;
            line_acc <= 1'b0;
            byte_hi  <= '0;
            row      <= '0;
            col      <= '0;
            mode_q   <= MODE_GRAY;
            dst_ip   <= '0;
            dst_mac  <= '0;
        end else begin
            href_d <= cam_href;
            if (cam_vsync) begin
                phase    <= 1'b0;
                line_acc <= 1'b0;
                row      <= '0;
                col      <= '0;
                mode_q   <= mode_e'(mode);
                dst_ip   <= pc_ip;
                dst_mac  <= pc_mac;
            end else if (cam_href) begin
                phase <= ~phase;
                if (!phase)
                    byte_hi <= cam_data;
                else if (col < cmos_h)
                    col <= col + 16'd1;
                if (accept)
                    line_acc <= 1'b1;
            end else if (href_d) begin
                // Line end: a dangling first byte is simply forgotten by clearing phase.
                phase    <= 1'b0;
                col      <= '0;
                line_acc <= 1'b0;
                if (line_acc)
                    row <= row + 16'd1;
            end
        end
    end

    always_comb begin
        s0         = '0;
        s0.vld     = accept;
        s0.sof     = (row == 16'd0) && (col == 16'd0);
        s0.eol     = (col == cmos_h - 16'd1);
        s0.last    = (row == cmos_v - 16'd1) && (col == cmos_h - 16'd1);
        s0.edge_ok = (row >= 16'd2) && (col >= 16'd2);
        s0.rgb     = rgb;
        s0.gray    = gray;
    end

    sobel_window3x3 #(
        .MAX_H (MAX_H),
        .AW    (AW)
    ) u_window (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (accept),
        .in_col  (col[AW-1:0]),
        .in_gray (gray),
        .mag     (mag)
    );

    assign mag_m = s3.edge_ok ? mag : 8'd0;

    always_comb begin
        out_data = '0;
        case (mode_q)
            MODE_GRAY:  out_data = {8'h00, s3.gray};
            MODE_SOBEL: out_data = {8'h00, mag_m};
            MODE_RAW:   out_data = s3.rgb;
            MODE_BIN:   out_data = (mag_m >= 8'(BIN_THRESH)) ? 16'hFFFF : 16'h0000;
            default:    out_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            done_tgl  <= 1'b0;
        end else begin
            s1        <= s0;
            s2        <= s1;
            s3        <= s2;
            pix_valid <= s3.vld;
            pix_data  <= s3.vld ? out_data : 16'h0000;
            pix_sof   <= s3.vld & s3.sof;
            pix_eol   <= s3.vld & s3.eol;
            done_tgl  <= done_tgl ^ (s3.vld & s3.last);
        end
    end

    // Two synchronizer flops, a third for edge detect, registered pulse.
    logic [2:0] done_sync;

    always_ff @(posedge eth_clk) begin
        if (!rst_n) begin
            done_sync      <= '0;
            frame_done_eth <= 1'b0;
        end else begin
            done_sync      <= {done_sync[1:0], done_tgl};
            frame_done_eth <= done_sync[2] ^ done_sync[1];
        end
    end

endmodule

// File: tb/tb_cmos_to_sobel.sv
module tb_cmos_to_sobel;

    logic        clk = 1'b0;
    logic        eth_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic [15:0] cmos_h = 16'd0;
    logic [15:0] cmos_v = 16'd0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] pc_ip = 32'd0;
    logic [47:0] pc_mac = 48'd0;
    logic        pix_valid, pix_sof, pix_eol, frame_done_eth;
    logic [15:0] pix_data;
    logic [31:0] dst_ip;
    logic [47:0] dst_mac;

    always #5 clk = ~clk;
    always #7 eth_clk = ~eth_clk;

    cmos_to_sobel dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .eth_clk        (eth_clk),
        .cam_vsync      (cam_vsync),
        .cam_href       (cam_href),
        .cam_data       (cam_data),
        .cmos_h         (cmos_h),
        .cmos_v         (cmos_v),
        .mode           (mode),
        .pc_ip          (pc_ip),
        .pc_mac         (pc_mac),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .pix_sof        (pix_sof),
        .pix_eol        (pix_eol),
        .dst_ip         (dst_ip),
        .dst_mac        (dst_mac),
        .frame_done_eth (frame_done_eth)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eol;
        int          due;
    } exp_t;
    exp_t expq[$];

    int n_valid = 0, n_sof = 0, n_eol = 0, n_done = 0, n_252 = 0, n_ffff = 0;
    int exp_done = 0;
    logic [15:0] last_data = 16'h0;

    // Reference frame state
    int gmap [16][16];
    int cur_mode = 0, fh = 0, fv = 0, row_m = 0;
    logic [7:0] line_q[$];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int gray_of(input logic [15:0] rgb);
        int r5, g6, b5;
        r5 = int'(rgb[15:11]);
        g6 = int'(rgb[10:5]);
        b5 = int'(rgb[4:0]);
        return (4 * (r5 * 8) + 10 * (g6 * 4) + 2 * (b5 * 8)) / 16;
    endfunction

    function automatic int mag_at(input int r, input int c);
        int p [3][3];
        int gx, gy, s;
        if (r < 2 || c < 2) return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                p[i][j] = gmap[r - 2 + i][c - 2 + j];
        gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (s > 255) ? 255 : s;
    endfunction

    function automatic logic [15:0] exp_value(input logic [15:0] rgb, input int r, input int c);
        int m;
        m = mag_at(r, c);
        case (cur_mode)
            0:       return 16'(gray_of(rgb));
            1:       return 16'(m);
            2:       return rgb;
            default: return (m >= 128) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge eth_clk);
            if (rst_n && frame_done_eth) n_done++;
        end
    end

    // Output monitor against the expectation queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (expq.size() > 0 && expq[0].due < cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_output actual=none required=%0h at cycle %0d", expq[0].data, expq[0].due);
                void'(expq.pop_front());
            end
            if (rst_n && pix_valid) begin
                n_valid++;
                if (pix_sof) n_sof++;
                if (pix_eol) n_eol++;
                if (pix_data == 16'd252) n_252++;
                if (pix_data == 16'hFFFF) n_ffff++;
                last_data = pix_data;
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=none", pix_data);
                end else begin
                    e = expq.pop_front();
                    check(pix_data == e.data, "pix_data", 64'(pix_data), 64'(e.data));
                    check({pix_sof, pix_eol} == {e.sof, e.eol}, "sof_eol", 64'({pix_sof, pix_eol}), 64'({e.sof, e.eol}));
                    check(cyc == e.due, "latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    task automatic start_frame(input int h, input int v, input int md, input logic [31:0] ip, input logic [47:0] mac);
        @(negedge clk);
        cmos_h = 16'(h);
        cmos_v = 16'(v);
        mode = 2'(md);
        pc_ip = ip;
        pc_mac = mac;
        cam_href = 1'b0;
        cam_vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cam_vsync = 1'b0;
        repeat (3) @(negedge clk);
        fh = h;
        fv = v;
        cur_mode = md;
        row_m = 0;
    endtask

    task automatic send_line();
        bit acc;
        int c;
        logic [7:0] hi;
        logic [15:0] rgb;
        exp_t e;
        acc = 1'b0;
        hi = 8'h00;
        for (int k = 0; k < line_q.size(); k++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = line_q[k];
            if (k % 2 == 0) begin
                hi = line_q[k];
            end else begin
                c = k / 2;
                if (c < fh && row_m < fv) begin
                    rgb = {hi, line_q[k]};
                    gmap[row_m][c] = gray_of(rgb);
                    e.data = exp_value(rgb, row_m, c);
                    e.sof = (row_m == 0 && c == 0);
                    e.eol = (c == fh - 1);
                    e.due = cyc + 4;
                    expq.push_back(e);
                    acc = 1'b1;
                    if (row_m == fv - 1 && c == fh - 1) exp_done++;
                end
            end
        end
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (4) @(negedge clk);
        if (acc) row_m++;
    endtask

    task automatic fill_uniform(input int npix, input logic [7:0] b0, input logic [7:0] b1);
        line_q.delete();
        for (int i = 0; i < npix; i++) begin
            line_q.push_back(b0);
            line_q.push_back(b1);
        end
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (n_done < exp_done && t < 40) begin
            @(negedge eth_clk);
            t++;
        end
        repeat (10) @(negedge eth_clk);
        check(n_done == exp_done, name, 64'(n_done), 64'(exp_done));
    endtask

    typedef struct {
        int          md;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_last;
    } vec_t;
    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 8'h0B, 8'h01, 16'h003F};
        vecs[1] = '{1, 8'h0B, 8'h01, 16'h0000};
        vecs[2] = '{2, 8'hF8, 8'h1F, 16'hF81F};
        vecs[3] = '{3, 8'hFF, 8'hFF, 16'h0000};
        vecs[4] = '{0, 8'hFF, 8'hFF, 16'h00FA};
        vecs[5] = '{0, 8'h00, 8'h00, 16'h0000};
        vecs[6] = '{2, 8'h12, 8'h34, 16'h1234};
        vecs[7] = '{0, 8'hF8, 8'h00, 16'h003E};
        vecs[8] = '{0, 8'h07, 8'hE0, 16'h009D};
        vecs[9] = '{0, 8'h00, 8'h1F, 16'h001F};

        rst_n = 1'b0;
        repeat (6) @(negedge clk);
        check(pix_valid == 1'b0, "rst_pix_valid", 64'(pix_valid), 64'(0));
        check(pix_data == 16'h0, "rst_pix_data", 64'(pix_data), 64'(0));
        check({pix_sof, pix_eol} == 2'b00, "rst_sof_eol", 64'({pix_sof, pix_eol}), 64'(0));
        check(dst_ip == 32'h0, "rst_dst_ip", 64'(dst_ip), 64'(0));
        check(dst_mac == 48'h0, "rst_dst_mac", 64'(dst_mac), 64'(0));
        check(frame_done_eth == 1'b0, "rst_frame_done", 64'(frame_done_eth), 64'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Uniform 4x4 frames, last pixel compared against the table
        for (int v = 0; v < 10; v++) begin
            start_frame(4, 4, vecs[v].md, 32'h0A000001 + 32'(v), 48'h0);
            fill_uniform(4, vecs[v].b0, vecs[v].b1);
            for (int r = 0; r < 4; r++) send_line();
            repeat (4) @(negedge clk);
            check(last_data == vecs[v].exp_last, "table_last_pixel", 64'(last_data), 64'(vecs[v].exp_last));
            wait_done("table_frame_done");
        end

        // 10x10 gray frame: output counts and one frame_done
        n_valid = 0; n_sof = 0; n_eol = 0;
        start_frame(10, 10, 0, 32'h01020304, 48'h112233445566);
        fill_uniform(10, 8'h0B, 8'h01);
        for (int r = 0; r < 10; r++) send_line();
        repeat (4) @(negedge clk);
        check(n_valid == 100, "count_valid", 64'(n_valid), 64'(100));
        check(n_eol == 10, "count_eol", 64'(n_eol), 64'(10));
        check(n_sof == 1, "count_sof", 64'(n_sof), 64'(1));
        check(dst_mac == 48'h112233445566, "dst_mac", 64'(dst_mac), 64'(48'h112233445566));
        wait_done("plan_frame_done");

        // Horizontal step: zeros above, gray 63 below, in sobel and binary modes
        for (int md = 1; md <= 3; md += 2) begin
            n_252 = 0; n_ffff = 0;
            start_frame(10, 10, md, 32'h0, 48'h0);
            for (int r = 0; r < 10; r++) begin
                if (r < 5) fill_uniform(10, 8'h00, 8'h00);
                else fill_uniform(10, 8'h0B, 8'h01);
                send_line();
            end
            repeat (4) @(negedge clk);
            if (md == 1) check(n_252 == 16, "step_mag_252", 64'(n_252), 64'(16));
            else check(n_ffff == 16, "step_bin_ffff", 64'(n_ffff), 64'(16));
            wait_done("step_frame_done");
        end

        // Raw mode with a 21-byte line: trailing byte dropped
        n_valid = 0;
        start_frame(10, 2, 2, 32'h0, 48'h0);
        fill_uniform(10, 8'hF8, 8'h1F);
        line_q.push_back(8'hAA);
        send_line();
        send_line();
        repeat (4) @(negedge clk);
        check(n_valid == 20, "odd_byte_valid", 64'(n_valid), 64'(20));
        check(last_data == 16'hF81F, "raw_last", 64'(last_data), 64'(16'hF81F));
        wait_done("raw_frame_done");

        // Frame aborted by a vsync at line 5
        start_frame(10, 10, 0, 32'h0, 48'h0);
        fill_uniform(10, 8'h31, 8'h7A);
        for (int r = 0; r < 5; r++) send_line();
        n_sof = 0;
        start_frame(10, 10, 0, 32'hC0A8010A, 48'hA1B2C3D4E5F6);
        wait_done("abort_no_done");
        check(dst_ip == 32'hC0A8010A, "abort_dst_ip", 64'(dst_ip), 64'(32'hC0A8010A));
        check(dst_mac == 48'hA1B2C3D4E5F6, "abort_dst_mac", 64'(dst_mac), 64'(48'hA1B2C3D4E5F6));
        for (int r = 0; r < 10; r++) send_line();
        repeat (4) @(negedge clk);
        check(n_sof == 1, "restart_sof", 64'(n_sof), 64'(1));
        wait_done("restart_frame_done");

        // Random frames: sizes, modes, over-long lines and surplus lines
        for (int f = 0; f < 8; f++) begin
            int h, v, extra_l;
            h = int'($urandom_range(3, 12));
            v = int'($urandom_range(3, 12));
            extra_l = int'($urandom_range(0, 2));
            start_frame(h, v, int'($urandom_range(0, 3)), $urandom, {$urandom, 16'($urandom)});
            for (int r = 0; r < v + extra_l; r++) begin
                int nb;
                nb = 2 * h + int'($urandom_range(0, 3));
                line_q.delete();
                for (int k = 0; k < nb; k++) line_q.push_back(8'($urandom));
                send_line();
            end
            wait_done("random_frame_done");
        end

        repeat (10) @(negedge clk);
        check(expq.size() == 0, "queue_drained", 64'(expq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmos_to_sobel.md
# cmos_to_sobel

Camera-side video processing block between the DVP camera capture pins and the UDP transmit path. It assembles RGB565 pixels from an 8-bit camera bus and converts them to 8-bit grayscale. It computes a 3x3 Sobel edge magnitude and outputs a mode-selected pixel stream in the clk domain. It also latches destination IP/MAC per frame for the UDP builder and signals frame completion into the eth_clk domain.

## Interface
- MAX_H, 1280: maximum line width in pixels; sets line-buffer depth.
- clk  in  1  pixel/camera clock.
- rst_n  in  1  reset, synchronous, active-low, sampled on clk (eth-side flops sample it on eth_clk).
- eth_clk  in  1  Ethernet transmit clock; asynchronous to clk.
- cam_vsync  in  1  active-high frame-start pulse.
- cam_href  in  1  high while line bytes are valid.
- cam_data  in  8  camera byte.
- cmos_h  in  16  active pixels per line (≤ MAX_H).
- cmos_v  in  16  active lines per frame.
- mode  in  2  output select.
- pc_ip  in  32  destination IP.
- pc_mac  in  48  destination MAC.
- pix_valid  out  1  output pixel strobe.
- pix_data  out  16  output pixel.
- pix_sof  out  1  with first pixel of a frame.
- pix_eol  out  1  with last pixel of each line.
- dst_ip  out  32  latched pc_ip.
- dst_mac  out  48  latched pc_mac.
- frame_done_eth  out  1  one eth_clk-cycle pulse per completed frame.

## Operation
- cam_vsync high: clear row/col/byte-phase counters; latch mode, pc_ip→dst_ip, pc_mac→dst_mac. A vsync mid-frame aborts the frame: no frame_done, restart.
- Byte pairing on href: first byte = {R5,G6[5:3]}, second = {G6[2:0],B5}. An odd trailing byte at href fall is discarded. Pixels with col ≥ cmos_h and lines with row ≥ cmos_v are ignored. Row increments on href falling edge when ≥1 pixel was accepted.
- Gray: R8={R5,000}, G8={G6,00}, B8={B5,000}; gray=(4·R8+10·G8+2·B8)>>4 in 12-bit intermediate, result 8-bit (max 255, no overflow).
- Sobel: 3x3 gray window from two MAX_H×8 line buffers plus current line. Output emitted at input pixel (r,c) represents center (r−1,c−1).
  - gx=(p[0][2]+2p[1][2]+p[2][2])−(p[0][0]+2p[1][0]+p[2][0]).
  - gy=(p[2][0]+2p[2][1]+p[2][2])−(p[0][0]+2p[0][1]+p[0][2]).
  - Row 0 is the oldest. gx/gy are 11-bit signed.
  - mag=min(|gx|+|gy|,255).
  - If r<2 or c<2, output 0.
- mode: 00 → {8'h00,gray}; 01 → {8'h00,mag}; 10 → raw RGB565; 11 → 16'hFFFF if mag≥128 else 0. Mode is latched at vsync.
- Exactly one output per accepted pixel: cmos_h·cmos_v outputs per frame. pix_sof on (0,0); pix_eol on col cmos_h−1.
- Frame done: on the output of pixel (cmos_v−1,cmos_h−1), toggle a clk-domain flag. It passes through a 2-flop synchronizer plus edge detect in eth_clk, giving frame_done_eth for one eth_clk cycle.

## Timing
- pix_valid asserts exactly 3 clk cycles after the edge sampling the second byte. This latency holds in all modes; raw is delay-matched.
- Line buffers are written on the same cycle the pixel is accepted. Reads are combinational/registered such that the 3-cycle latency holds.
- frame_done_eth pulses 3–4 eth_clk cycles after the clk-side toggle.
- Reset: all outputs 0, counters 0, line-buffer contents don't-care (masked by r<2/c<2 rule), toggle/sync flops 0.

## Structure
- Shared package: mode encodings (MODE_GRAY, MODE_SOBEL, MODE_RAW, MODE_BIN), gray weights 4/10/2, shift 4, threshold 128.
- One sub-module: sobel_window3x3 (line buffers, window registers, gx/gy/mag).
- Top holds the byte assembler, gray conversion, counters, mode mux, latches and CDC.

## Test plan
- cmos_h=cmos_v=10; vsync pulse; 10 lines of 20 href bytes -> 100 pix_valid, 10 pix_eol, 1 pix_sof, exactly one frame_done_eth.
- mode=00, bytes 0x0B,0x01 repeated -> pix_data=16'h003F (gray 63), 3 cycles after each second byte.
- mode=01, uniform 0x0B/0x01 image -> all outputs 0.
- mode=01, lines 0–4 bytes 0x00, lines 5–9 0x0B/0x01 -> outputs at rows 5,6 with col≥2 = 252; all others 0. mode=11 same image -> those = 16'hFFFF.
- mode=10, bytes 0xF8,0x1F -> pix_data=16'hF81F. 21-byte line -> 10 pixels, odd byte dropped.
- Second vsync at line 5 with pc_ip=192.168.1.10 -> no frame_done_eth, dst_ip=32'hC0A8010A, counters restart at (0,0).
